// File: rtl/sram_map_arbiter_pkg.sv
// Shared constants for the SRAM-like channel arbiter and segment mapper.
// SRAM size encodings, MIPS segment selectors and id-width helper.
package sram_map_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    // A single channel still needs a one-bit id to keep vectors legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// Small FIFO of channel ids for outstanding downstream transactions.
// Count is one bit wider than the pointers so full and empty are distinct.
module sram_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic [W-1:0] id_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW:0]   cnt_q;
    logic [PW:0]   cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= id_i;
    end

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/sram_map_arbiter.sv
// Round-robin arbiter of NCH SRAM-like channels onto one bus, with
// kseg0/kseg1 fixed mapping and in-order response routing.
module sram_map_arbiter
    import sram_map_arbiter_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int DW           = 32,
    parameter int MAX_OUT      = 4,
    parameter bit KSEG0_CACHED = 1'b1,
    parameter bit KUSEG_CACHED = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NCH-1:0]    up_req,
    input  logic [NCH-1:0]    up_wr,
    input  logic [2*NCH-1:0]  up_size,
    input  logic [32*NCH-1:0] up_addr,
    input  logic [DW*NCH-1:0] up_wdata,
    output logic [NCH-1:0]    up_addr_ok,
    output logic [NCH-1:0]    up_data_ok,
    output logic [DW-1:0]     up_rdata,
    output logic              dn_req,
    output logic              dn_wr,
    output logic [1:0]        dn_size,
    output logic [31:0]       dn_addr,
    output logic [DW-1:0]     dn_wdata,
    output logic              dn_cached,
    input  logic              dn_addr_ok,
    input  logic              dn_data_ok,
    input  logic [DW-1:0]     dn_rdata,
    output logic              err_unexp
);

    localparam int IW = id_width(NCH);

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic          lock_q, lock_d;
    logic          err_q;
    logic [IW-1:0] grant;
    logic [IW-1:0] head;
    logic [31:0]   vaddr;
    logic          accept, pop, full, empty;

    function automatic logic [32:0] map_seg(input logic [31:0] va);
        unique case (va[31:29])
            SEG_KSEG0: return {KSEG0_CACHED, 3'b000, va[28:0]};
            SEG_KSEG1: return {1'b0, 3'b000, va[28:0]};
            default:   return {KUSEG_CACHED, va};
        endcase
    endfunction

    // First requester after last grant; a pending lock overrides it.
    always_comb begin
        logic found;
        int   idx;
        grant = last_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_q) + i) % NCH;
            if (!found && up_req[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
        if (lock_q) grant = lock_id_q;
    end

    always_comb begin
        int g;
        g        = int'(grant);
        dn_wr    = up_wr[g];
        dn_size  = up_size[2*g +: 2];
        vaddr    = up_addr[32*g +: 32];
        dn_wdata = up_wdata[DW*g +: DW];
        if (lock_q) dn_req = up_req[lock_id_q] & ~full;
        else        dn_req = (|up_req) & ~full;
    end

    assign {dn_cached, dn_addr} = map_seg(vaddr);

    assign accept   = dn_req & dn_addr_ok;
    assign pop      = dn_data_ok & ~empty;
    assign up_rdata = dn_rdata;
    assign err_unexp = err_q;

    always_comb begin
        up_addr_ok = '0;
        up_data_ok = '0;
        if (accept) up_addr_ok[grant] = 1'b1;
        if (pop)    up_data_ok[head]  = 1'b1;
    end

    always_comb begin
        last_d    = last_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            last_d = grant;
            lock_d = 1'b0;
        end else if (dn_req) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end else if (lock_q && !up_req[lock_id_q]) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q    <= IW'(NCH - 1);
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_q | (dn_data_ok & empty);
        end
    end

    sram_id_fifo #(
        .W     (IW),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (accept),
        .id_i    (grant),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_sram_map_arbiter.sv
// Scenario bench for sram_map_arbiter: expected channel ids are queued at
// acceptance and popped when the response comes back.
module tb_sram_map_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  up_req, up_wr;
    logic [3:0]  up_size;
    logic [63:0] up_addr, up_wdata;
    logic [1:0]  up_addr_ok, up_data_ok;
    logic [31:0] up_rdata;
    logic        dn_req, dn_wr, dn_cached;
    logic [1:0]  dn_size;
    logic [31:0] dn_addr, dn_wdata;
    logic        dn_addr_ok, dn_data_ok;
    logic [31:0] dn_rdata;
    logic        err_unexp;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int rr_last;

    always #5 clk = ~clk;

    sram_map_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .up_req     (up_req),
        .up_wr      (up_wr),
        .up_size    (up_size),
        .up_addr    (up_addr),
        .up_wdata   (up_wdata),
        .up_addr_ok (up_addr_ok),
        .up_data_ok (up_data_ok),
        .up_rdata   (up_rdata),
        .dn_req     (dn_req),
        .dn_wr      (dn_wr),
        .dn_size    (dn_size),
        .dn_addr    (dn_addr),
        .dn_wdata   (dn_wdata),
        .dn_cached  (dn_cached),
        .dn_addr_ok (dn_addr_ok),
        .dn_data_ok (dn_data_ok),
        .dn_rdata   (dn_rdata),
        .err_unexp  (err_unexp)
    );

    function automatic int rr_pick(input int last, input logic [1:0] req);
        for (int i = 1; i <= 2; i++)
            if (req[(last + i) % 2]) return (last + i) % 2;
        return last;
    endfunction

    function automatic logic [1:0] exp_pop();
        int e;
        if (exp_q.size() == 0) return 2'b00;
        e = exp_q.pop_front();
        return 2'b01 << e;
    endfunction

    task automatic drive_idle();
        up_req = '0; up_wr = '0; up_size = '0;
        up_addr = '0; up_wdata = '0;
        dn_addr_ok = 1'b0; dn_data_ok = 1'b0; dn_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive_idle();
        repeat (2) next_cycle();
        resetn = 1'b1;
        exp_q.delete();
        rr_last = 1;
        @(negedge clk);
        n_cmp++;
        if (dn_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_dn_req: got %b want 0", dn_req);
        end
        n_cmp++;
        if (up_addr_ok !== 2'b00) begin
            n_bad++; $display("FAIL reset_addr_ok: got %b want 00", up_addr_ok);
        end
        n_cmp++;
        if (up_data_ok !== 2'b00) begin
            n_bad++; $display("FAIL reset_data_ok: got %b want 00", up_data_ok);
        end
        n_cmp++;
        if (err_unexp !== 1'b0) begin
            n_bad++; $display("FAIL reset_err: got %b want 0", err_unexp);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        logic [1:0] ev;
        up_req = 2'b01;
        up_size = 4'b1010;
        up_addr[31:0] = 32'hBFC0_0000;
        dn_addr_ok = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (up_addr_ok !== 2'b01) begin
            n_bad++; $display("FAIL single_addr_ok: got %b want 01", up_addr_ok);
        end
        n_cmp++;
        if (dn_addr !== 32'h1FC0_0000) begin
            n_bad++; $display("FAIL single_dn_addr: got %h want 1fc00000", dn_addr);
        end
        n_cmp++;
        if (dn_cached !== 1'b0 || dn_size !== 2'd2 || dn_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL single_attr: got c=%b s=%0d w=%b want c=0 s=2 w=0",
                     dn_cached, dn_size, dn_wr);
        end
        exp_q.push_back(0);
        rr_last = 0;
        next_cycle();
        up_req = 2'b00;
        dn_addr_ok = 1'b0;
        dn_data_ok = 1'b1;
        dn_rdata = 32'h1234;
        @(negedge clk);
        ev = exp_pop();
        n_cmp++;
        if (up_data_ok !== ev || up_rdata !== 32'h1234) begin
            n_bad++;
            $display("FAIL single_resp: got ok=%b d=%h want ok=%b d=00001234",
                     up_data_ok, up_rdata, ev);
        end
        next_cycle();
        dn_data_ok = 1'b0;
    endtask

    task automatic test_contention();
        int g;
        logic [1:0] ev;
        up_req = 2'b11;
        up_wr = 2'b10;
        up_addr = {32'h0040_0000, 32'h8000_1000};
        up_wdata = {32'hAAAA_0001, 32'hBBBB_0000};
        dn_addr_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dn_data_ok = (k > 0);
            dn_rdata = 32'h100 + k;
            g = rr_pick(rr_last, 2'b11);
            @(negedge clk);
            n_cmp++;
            if (up_addr_ok !== (2'b01 << g)) begin
                n_bad++;
                $display("FAIL cont_grant%0d: got %b want ch%0d", k, up_addr_ok, g);
            end
            n_cmp++;
            if (dn_addr !== (g == 0 ? 32'h0000_1000 : 32'h0040_0000) ||
                dn_cached !== 1'b1 || dn_wr !== (g == 1)) begin
                n_bad++;
                $display("FAIL cont_payload%0d: got a=%h c=%b w=%b for ch%0d",
                         k, dn_addr, dn_cached, dn_wr, g);
            end
            if (k > 0) begin
                ev = exp_pop();
                n_cmp++;
                if (up_data_ok !== ev || up_rdata !== 32'h100 + k) begin
                    n_bad++;
                    $display("FAIL cont_resp%0d: got %b/%h want %b/%h",
                             k, up_data_ok, up_rdata, ev, 32'h100 + k);
                end
            end
            exp_q.push_back(g);
            rr_last = g;
            next_cycle();
        end
        up_req = 2'b00;
        dn_addr_ok = 1'b0;
        dn_data_ok = 1'b1;
        dn_rdata = 32'h105;
        @(negedge clk);
        ev = exp_pop();
        n_cmp++;
        if (up_data_ok !== ev) begin
            n_bad++; $display("FAIL cont_last_resp: got %b want %b", up_data_ok, ev);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_lock();
        logic [1:0] ev;
        up_req = 2'b10;
        up_addr = {32'h0000_2000, 32'h9000_0000};
        dn_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dn_req !== 1'b1 || up_addr_ok !== 2'b00 || dn_addr !== 32'h2000) begin
                n_bad++;
                $display("FAIL lock_wait%0d: got r=%b ok=%b a=%h want 1/00/2000",
                         k, dn_req, up_addr_ok, dn_addr);
            end
            next_cycle();
        end
        up_req = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (dn_addr !== 32'h2000 || up_addr_ok !== 2'b00) begin
            n_bad++;
            $display("FAIL lock_hold: got a=%h ok=%b want 2000/00", dn_addr, up_addr_ok);
        end
        next_cycle();
        dn_addr_ok = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (up_addr_ok !== 2'b10 || dn_addr !== 32'h2000) begin
            n_bad++;
            $display("FAIL lock_accept: got ok=%b a=%h want 10/2000", up_addr_ok, dn_addr);
        end
        exp_q.push_back(1);
        rr_last = 1;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (up_addr_ok !== 2'b01 || dn_addr !== 32'h1000_0000 || dn_cached !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_next: got ok=%b a=%h c=%b want 01/10000000/1",
                     up_addr_ok, dn_addr, dn_cached);
        end
        exp_q.push_back(0);
        rr_last = 0;
        next_cycle();
        up_req = 2'b00;
        dn_addr_ok = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dn_data_ok = 1'b1;
            dn_rdata = 32'h300 + k;
            @(negedge clk);
            ev = exp_pop();
            n_cmp++;
            if (up_data_ok !== ev) begin
                n_bad++; $display("FAIL lock_resp%0d: got %b want %b", k, up_data_ok, ev);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_full();
        int g;
        logic [1:0] ev;
        up_req = 2'b11;
        up_addr = {32'hA000_0010, 32'hC000_0000};
        dn_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = rr_pick(rr_last, 2'b11);
            @(negedge clk);
            n_cmp++;
            if (up_addr_ok !== (2'b01 << g) ||
                dn_addr !== (g == 0 ? 32'hC000_0000 : 32'h0000_0010) ||
                dn_cached !== (g == 0)) begin
                n_bad++;
                $display("FAIL full_fill%0d: got ok=%b a=%h c=%b for ch%0d",
                         k, up_addr_ok, dn_addr, dn_cached, g);
            end
            exp_q.push_back(g);
            rr_last = g;
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (dn_req !== 1'b0 || up_addr_ok !== 2'b00) begin
            n_bad++;
            $display("FAIL full_block: got r=%b ok=%b want 0/00", dn_req, up_addr_ok);
        end
        next_cycle();
        dn_data_ok = 1'b1;
        dn_rdata = 32'h200;
        @(negedge clk);
        ev = exp_pop();
        n_cmp++;
        if (dn_req !== 1'b0 || up_data_ok !== ev) begin
            n_bad++;
            $display("FAIL full_pop: got r=%b ok=%b want 0/%b", dn_req, up_data_ok, ev);
        end
        next_cycle();
        dn_rdata = 32'h201;
        g = rr_pick(rr_last, 2'b11);
        @(negedge clk);
        ev = exp_pop();
        n_cmp++;
        if (dn_req !== 1'b1 || up_addr_ok !== (2'b01 << g) || up_data_ok !== ev) begin
            n_bad++;
            $display("FAIL full_pushpop: got r=%b a=%b d=%b want 1/ch%0d/%b",
                     dn_req, up_addr_ok, up_data_ok, g, ev);
        end
        exp_q.push_back(g);
        rr_last = g;
        next_cycle();
        dn_data_ok = 1'b0;
        g = rr_pick(rr_last, 2'b11);
        @(negedge clk);
        n_cmp++;
        if (up_addr_ok !== (2'b01 << g)) begin
            n_bad++; $display("FAIL full_refill: got %b want ch%0d", up_addr_ok, g);
        end
        exp_q.push_back(g);
        rr_last = g;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (dn_req !== 1'b0) begin
            n_bad++; $display("FAIL full_again: got %b want 0", dn_req);
        end
        up_req = 2'b00;
        dn_addr_ok = 1'b0;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            dn_data_ok = 1'b1;
            dn_rdata = 32'h400 + k;
            @(negedge clk);
            ev = exp_pop();
            n_cmp++;
            if (up_data_ok !== ev || up_rdata !== 32'h400 + k) begin
                n_bad++;
                $display("FAIL full_drain%0d: got %b/%h want %b/%h",
                         k, up_data_ok, up_rdata, ev, 32'h400 + k);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_unexpected();
        drive_idle();
        dn_data_ok = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (up_data_ok !== 2'b00 || err_unexp !== 1'b0) begin
            n_bad++;
            $display("FAIL unexp_pre: got ok=%b e=%b want 00/0", up_data_ok, err_unexp);
        end
        next_cycle();
        dn_data_ok = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_unexp !== 1'b1) begin
            n_bad++; $display("FAIL unexp_set: got %b want 1", err_unexp);
        end
        repeat (3) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (err_unexp !== 1'b1) begin
            n_bad++; $display("FAIL unexp_sticky: got %b want 1", err_unexp);
        end
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (err_unexp !== 1'b0) begin
            n_bad++; $display("FAIL unexp_clear: got %b want 0", err_unexp);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_full();
        test_unexpected();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
